uart_rx_frontend: RTL and testbench
===================================

# uart_rx_frontend

Oversampling-free UART receive front end: synchronises the raw `rx` pin, validates the start bit at mid-bit, samples 8N1 frames at bit centre, checks the stop bit, and queues received bytes in a small show-ahead FIFO with a valid/ready handshake. It sits directly upstream of the byte buffer/echo stage and replaces its ad-hoc shift-register capture with framed, error-flagged bytes.

## Interface
- `FREQ`, 12000000, clock frequency in Hz
- `BAUD`, 9600, line rate; `DIV` = FREQ/BAUD (1250 at defaults), `HALF` = DIV/2 (625)
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  sole clock; all logic on posedge
- `rst`  in  1  reset; synchronous, active-high
- `rx`  in  1  asynchronous serial input; idle high
- `rx_data`  out  8  FIFO head byte; valid only while `rx_valid`
- `rx_valid`  out  1  FIFO not empty
- `rx_ready`  in  1  consumer accepts head when `rx_valid && rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: good byte dropped, FIFO full
- `busy`  out  1  high whenever FSM not in IDLE
- `fifo_count`  out  log2(DEPTH)+1  entries held (0..DEPTH)

## Operation
- Input sync: two flops, both reset to 1; `rx_s` = second flop. No other logic sees `rx`.
- Counter `cnt`: 20 bits, cleared on every state entry, incremented each cycle in START/DATA/STOP.
- States:
  - IDLE: `rx_s==0` -> START.
  - START: at `cnt==HALF-1` sample `rx_s`; 0 -> DATA (bit index 0); 1 -> IDLE (false start, no flags).
  - DATA: at `cnt==DIV-1` shift `rx_s` into shift register LSB-first (shift right, new bit into bit 7), clear `cnt`; after bit index 7 -> STOP.
  - STOP: at `cnt==DIV-1` sample `rx_s`; 1 -> push byte, -> IDLE; 0 -> pulse `frame_err`, discard byte, -> BREAK.
  - BREAK: wait for `rx_s==1`, then -> IDLE. Held-low line yields exactly one `frame_err`.
- FIFO: circular, read/write pointers log2(DEPTH)+1 bits, wrap naturally; `rx_data` = mem[rd], show-ahead.
- Push accepted if not full, or if a pop occurs the same cycle. Otherwise byte dropped and `overrun` pulses.
- Pop when `rx_valid && rx_ready`; pop when empty impossible (`rx_valid` low).
- Simultaneous push+pop: count unchanged, both pointers advance, ordering preserved (including full and DEPTH-1 cases).
- `frame_err` and `overrun` never assert in the same cycle (single stop-sample event).

## Timing
- Reset (`rst` high at a posedge): FSM IDLE, sync flops 1, `cnt` 0, pointers 0; `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, `fifo_count`=0. Reset mid-frame abandons the frame; no flags, no push.
- `rx` falling at cycle t: `rx_s` low at t+2, FSM in START at t+3, `busy` high at t+3.
- Start check at START+HALF cycles; bit k sample at START+HALF+(k+1)·DIV; stop sample at START+HALF+9·DIV (11875 cycles at defaults).
- Byte written on the stop-sample edge; `rx_valid` and updated `fifo_count` visible the next cycle; `busy` low the same next cycle.
- Mid-stop-bit return to IDLE gives half a bit of slack for next start edge; back-to-back frames at full line rate are received without loss when `rx_ready`=1.
- Pop takes effect on the handshake edge; new head on `rx_data` next cycle.
- False start: glitch shorter than HALF-2 cycles -> IDLE after HALF cycles, nothing else changes.

## Test plan
- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 1250 cycles/bit, `rx_ready`=1 -> `rx_valid` one cycle with `rx_data`=0xA5 exactly 11875+3 cycles after falling edge; no flags.
- `rx` low for 300 cycles then high -> `busy` high ~625 cycles, returns IDLE; no push, no flags.
- Frame 0x3C with stop bit 0, then line high -> single `frame_err` pulse, `fifo_count` stays 0; next valid frame 0x11 received correctly.
- Line held low 50000 cycles -> exactly one `frame_err`, FSM parked in BREAK until high.
- Bytes 0x01..0x05 back-to-back, `rx_ready`=0 -> `fifo_count`=4, `overrun` pulses on 5th; then `rx_ready`=1 drains 0x01,0x02,0x03,0x04 in order.
- FIFO full, `rx_ready` asserted on the stop-sample cycle of a 6th byte 0x06 -> no `overrun`, count stays 4, drain order 0x02,0x03,0x04,0x06; `rst` pulsed mid-byte -> all outputs reset values, next frame 0x7E received.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 8N1 UART receiver with mid-bit sampling, stop-bit check and show-ahead byte FIFO
module uart_rx_frontend #(
    parameter int FREQ  = 12000000,
    parameter int BAUD  = 9600,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int DIV  = FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int AW   = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state, state_n;
    logic        rx_q1, rx_s;
    logic [19:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        push, frame_err_n;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, pop, push_ok;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = '0;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        push        = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                cnt_n = cnt + 20'd1;
                if (cnt == 20'(HALF - 1)) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n   = S_DATA;
                        bit_idx_n = 3'd0;
                    end
                end
            end
            S_DATA: begin
                cnt_n = cnt + 20'd1;
                if (cnt == 20'(DIV - 1)) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = S_STOP;
                    else bit_idx_n = bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                cnt_n = cnt + 20'd1;
                if (cnt == 20'(DIV - 1)) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line parks here so it reports only one framing error.
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign fifo_count = wr_ptr - rd_ptr;
    assign rx_valid   = (fifo_count != '0);
    assign full       = (fifo_count == (AW + 1)'(DEPTH));
    assign pop        = rx_valid && rx_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign push_ok    = push && (!full || pop);
    assign rx_data    = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && !push_ok;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - scoreboard bench for uart_rx_frontend with directed frames
module tb_uart_rx_frontend;

    localparam int FREQ  = 320000;
    localparam int BAUD  = 10000;
    localparam int DIV   = FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] fifo_count;

    uart_rx_frontend #(.FREQ(FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pop_cnt = 0;
    int last_pop_cyc = 0;
    int e0_cyc = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and tallies flag pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err || overrun) check("flag_overlap", {31'd0, frame_err && overrun}, 32'd0);
            if (rx_valid && rx_ready) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %0h expected none", rx_data);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Start bit, 8 data bits LSB first, stop bit; next call continues at full line rate.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1 rx = 1'b0;
        e0_cyc = cyc;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (DIV) @(posedge clk);
        end
        #1 rx = stop;
        repeat (DIV - 1) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 0xA5 with latency and busy-onset timing
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("busy_t2", busy, 0);
                @(negedge clk);
                check("busy_t3", busy, 1);
            end
        join
        repeat (DIV) @(posedge clk);
        check("a5_pops", pop_cnt, 1);
        check("a5_latency", last_pop_cyc - e0_cyc, 3 + HALF + 9 * DIV);
        check("a5_flags", fe_cnt + ov_cnt, 0);

        // false start glitch
        bc = 0;
        @(posedge clk);
        #1 rx = 1'b0;
        for (int i = 0; i < HALF + 40; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (i == 7) rx = 1'b1;
        end
        check("glitch_busy_cycles", bc, HALF);
        check("glitch_pops", pop_cnt, 1);
        check("glitch_count", fifo_count, 0);
        check("glitch_flags", fe_cnt + ov_cnt, 0);

        // framing error then a good frame
        send_frame(8'h3C, 1'b0);
        repeat (3 * DIV) @(posedge clk);
        @(negedge clk);
        check("fe_pulses", fe_cnt, 1);
        check("fe_count", fifo_count, 0);
        check("fe_busy", busy, 0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        repeat (2 * DIV) @(posedge clk);
        check("after_fe_rx", exp_q.size(), 0);

        // held-low line parks in BREAK with one frame error
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        check("break_busy", busy, 1);
        check("break_fe", fe_cnt, 2);
        rx = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("break_release", busy, 0);
        check("break_fe_after", fe_cnt, 2);
        check("break_pops", pop_cnt, 2);

        // fill FIFO, overflow on fifth byte
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        check("full_count", fifo_count, 4);
        check("full_overrun", ov_cnt, 1);
        check("full_head", rx_data, 8'h01);

        // pop coincident with push into a full FIFO
        exp_q.push_back(8'h06);
        fork
            send_frame(8'h06, 1'b1);
            begin
                @(posedge clk);
                repeat (2 + HALF + 9 * DIV) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        check("pp_overrun", ov_cnt, 1);
        check("pp_count", fifo_count, 4);
        check("pp_head", rx_data, 8'h02);
        rx_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("drain_count", fifo_count, 0);

        // reset mid-frame with a byte held in the FIFO
        rx_ready = 1'b0;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        repeat (DIV) @(posedge clk);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_count", fifo_count, 1);
        rst = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_flags", {30'd0, frame_err, overrun}, 0);

        rx_ready = 1'b1;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        repeat (2 * DIV) @(posedge clk);
        check("post_rst_rx", exp_q.size(), 0);
        check("final_fe", fe_cnt, 2);
        check("final_ov", ov_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
